io_mmio_ctrl: RTL and testbench

//   Memory-mapped IO block for the RISC-V core's 0x8000_00xx space.
//   - Replaces the inline iomem array with buffered UART RX/TX FIFOs, a cycle counter, a retired-instruction counter and NUM_EVT event counters.
//   - Sits between the core's MEM stage (word-aligned offset, byte enables) and the on-chip uart ready/valid ports.

---
 rtl/io_mmio_pkg.sv | 13 +
 rtl/io_mmio_ctrl_sync_fifo.sv | 45 ++++
 rtl/io_mmio_ctrl.sv | 137 +++++++++++++
 tb/tb_io_mmio_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_mmio_pkg.sv
// Register offsets for the 0x8000_00xx memory-mapped IO window.
package io_mmio_pkg;

  localparam logic [7:0] IO_STAT = 8'h00;
  localparam logic [7:0] IO_RXD  = 8'h04;
  localparam logic [7:0] IO_TXD  = 8'h08;
  localparam logic [7:0] IO_FLAG = 8'h0C;
  localparam logic [7:0] IO_CYC  = 8'h10;
  localparam logic [7:0] IO_INST = 8'h14;
  localparam logic [7:0] IO_CLR  = 8'h18;
  localparam logic [7:0] IO_EVT0 = 8'h20;

endpackage

// File: rtl/io_mmio_ctrl_sync_fifo.sv
// Show-ahead synchronous FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_mmio_ctrl.sv
// MMIO block: buffered UART RX/TX, cycle/instret/event counters and a registered read port.
module io_mmio_ctrl
  import io_mmio_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 8,
  parameter int NUM_EVT  = 2,
  parameter int CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         addr,
  input  logic               wr_en,
  input  logic [3:0]         wr_be,
  input  logic [31:0]        wr_data,
  input  logic               rd_en,
  output logic [31:0]        rd_data,
  output logic               rd_valid,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  input  logic               inst_ret,
  input  logic [NUM_EVT-1:0] evt
);

  logic [7:0]       w_off;
  logic             w_rx_pop;
  logic             w_rx_full;
  logic             w_rx_empty;
  logic [7:0]       w_rx_dout;
  logic             w_tx_push;
  logic             w_tx_full;
  logic             w_tx_empty;
  logic             w_drop_set;
  logic             w_flag_clr;
  logic             w_cnt_clr;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  logic             r_tx_drop;
  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_inst;
  logic [CNT_W-1:0] r_evt [NUM_EVT];
  logic [31:0]      r_rd_data;
  logic             r_rd_valid;

  assign w_off      = {addr[7:2], 2'b00};
  assign w_rx_pop   = rd_en && (w_off == IO_RXD);
  assign w_tx_push  = wr_en && (w_off == IO_TXD) && wr_be[0];
  assign w_drop_set = w_tx_push && w_tx_full && !tx_ready;
  assign w_flag_clr = wr_en && (w_off == IO_FLAG) && wr_be[0] && wr_data[0];
  assign w_cnt_clr  = wr_en && (w_off == IO_CLR) && (|wr_be);
  assign w_unused   = &{1'b0, addr[1:0], wr_data[31:8]};

  // The uart may still offer a byte while full; it lands if a read frees a slot.
  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_valid),
    .pop   (w_rx_pop),
    .din   (rx_data),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_tx_push),
    .pop   (tx_ready),
    .din   (wr_data[7:0]),
    .dout  (tx_data),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  assign rx_ready = !w_rx_full;
  assign tx_valid = !w_tx_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_drop <= 1'b0;
    end else begin
      r_tx_drop <= w_drop_set || (r_tx_drop && !w_flag_clr);
    end
  end

  // Clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc  <= '0;
      r_inst <= '0;
      for (int i = 0; i < NUM_EVT; i++) r_evt[i] <= '0;
    end else if (w_cnt_clr) begin
      r_cyc  <= '0;
      r_inst <= '0;
      for (int i = 0; i < NUM_EVT; i++) r_evt[i] <= '0;
    end else begin
      r_cyc  <= r_cyc + CNT_W'(1);
      r_inst <= r_inst + CNT_W'(inst_ret);
      for (int i = 0; i < NUM_EVT; i++) r_evt[i] <= r_evt[i] + CNT_W'(evt[i]);
    end
  end

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_off)
      IO_STAT: w_rd_mux = {30'd0, !w_rx_empty, !w_tx_full};
      IO_RXD:  w_rd_mux = w_rx_empty ? 32'd0 : {24'd0, w_rx_dout};
      IO_FLAG: w_rd_mux = {31'd0, r_tx_drop};
      IO_CYC:  w_rd_mux = 32'(r_cyc);
      IO_INST: w_rd_mux = 32'(r_inst);
      default: w_rd_mux = 32'd0;
    endcase
    for (int i = 0; i < NUM_EVT; i++) begin
      if (w_off == IO_EVT0 + 8'(4 * i)) w_rd_mux = 32'(r_evt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= 32'd0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en) r_rd_data <= w_rd_mux;
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;

endmodule

// File: tb/tb_io_mmio_ctrl.sv
// Bench for io_mmio_ctrl: register-map table, directed FIFO/counter sequences, random traffic vs a queue model.
module tb_io_mmio_ctrl;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  addr;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_ready;
  logic        inst_ret;
  logic [1:0]  evt;

  logic [31:0] rd_data,  rd_data4;
  logic        rd_valid, rd_valid4;
  logic        rx_ready, rx_ready4;
  logic [7:0]  tx_data,  tx_data4;
  logic        tx_valid, tx_valid4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_mmio_ctrl #(.RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .NUM_EVT(2), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .inst_ret(inst_ret), .evt(evt)
  );

  // Narrow-counter instance shares every input so wrap behaviour can be observed side by side.
  io_mmio_ctrl #(.RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .NUM_EVT(2), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .wr_be(wr_be), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data4), .rd_valid(rd_valid4), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready4), .tx_data(tx_data4), .tx_valid(tx_valid4), .tx_ready(tx_ready),
    .inst_ret(inst_ret), .evt(evt)
  );

  // Reference model: byte queues for the FIFOs and unbounded counts masked on read.
  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  bit          mDrop;
  logic [63:0] mCyc, mInst;
  logic [63:0] mEvt[2];
  logic [31:0] mRd, mRd4;
  bit          mRdv;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [7:0] a, input int cw);
    logic [63:0] mask;
    mask = (64'd1 << cw) - 64'd1;
    case (a[7:2])
      6'd0: return {30'd0, rxq.size() != 0, txq.size() != DEPTH};
      6'd1: return (rxq.size() != 0) ? {24'd0, rxq[0]} : 32'd0;
      6'd3: return {31'd0, mDrop};
      6'd4: return 32'(mCyc & mask);
      6'd5: return 32'(mInst & mask);
      6'd8: return 32'(mEvt[0] & mask);
      6'd9: return 32'(mEvt[1] & mask);
      default: return 32'd0;
    endcase
  endfunction

  task automatic resetModel();
    rxq.delete();
    txq.delete();
    mDrop = 0;
    mCyc = 0;
    mInst = 0;
    mEvt[0] = 0;
    mEvt[1] = 0;
    mRd = 0;
    mRd4 = 0;
    mRdv = 0;
  endtask

  task automatic checkOutput();
    check("rd_valid", rd_valid, mRdv);
    check("rd_data", rd_data, mRd);
    check("rd_data_cw4", rd_data4, mRd4);
    check("rx_ready", rx_ready, rxq.size() < DEPTH);
    check("tx_valid", tx_valid, txq.size() > 0);
    if (txq.size() > 0) check("tx_data", tx_data, txq[0]);
  endtask

  // Advance one clock: model consumes the pre-edge inputs, DUT is compared just after the edge.
  task automatic step();
    bit txPush, clr, flagClr, dropSet;
    if (rd_en) begin
      mRd  = modelRead(addr, 32);
      mRd4 = modelRead(addr, 4);
    end
    mRdv = rd_en;
    if (rd_en && addr[7:2] == 6'd1 && rxq.size() > 0) void'(rxq.pop_front());
    if (rx_valid && rxq.size() < DEPTH) rxq.push_back(rx_data);
    if (tx_ready && txq.size() > 0) void'(txq.pop_front());
    txPush  = wr_en && addr[7:2] == 6'd2 && wr_be[0];
    dropSet = 0;
    if (txPush) begin
      if (txq.size() < DEPTH) txq.push_back(wr_data[7:0]);
      else dropSet = 1;
    end
    flagClr = wr_en && addr[7:2] == 6'd3 && wr_be[0] && wr_data[0];
    mDrop   = dropSet || (mDrop && !flagClr);
    clr     = wr_en && addr[7:2] == 6'd6 && wr_be != 4'h0;
    if (clr) begin
      mCyc = 0; mInst = 0; mEvt[0] = 0; mEvt[1] = 0;
    end else begin
      mCyc += 1;
      mInst += inst_ret;
      mEvt[0] += evt[0];
      mEvt[1] += evt[1];
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit re, input bit we, input logic [7:0] a,
                               input logic [3:0] be, input logic [31:0] wd);
    rd_en = re; wr_en = we; addr = a; wr_be = be; wr_data = wd;
    step();
  endtask

  initial begin
    logic [7:0] rdAddrs[10];
    logic [7:0] wrAddrs[6];
    rdAddrs = '{8'h00, 8'h04, 8'h04, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h3D};
    wrAddrs = '{8'h08, 8'h08, 8'h0A, 8'h0C, 8'h18, 8'h44};

    rst_n = 0; addr = 0; wr_en = 0; wr_be = 0; wr_data = 0; rd_en = 0;
    rx_data = 0; rx_valid = 0; tx_ready = 0; inst_ret = 0; evt = 0;
    resetModel();
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    check("reset_rd_data", rd_data, 32'd0);
    check("reset_rd_valid", rd_valid, 32'd0);
    check("reset_tx_valid", tx_valid, 32'd0);
    check("reset_rx_ready", rx_ready, 32'd1);

    // Register map straight after reset (constant expectations).
    tbl.push_back('{8'h00, 32'h1, "stat_reset"});
    tbl.push_back('{8'h04, 32'h0, "rxd_empty"});
    tbl.push_back('{8'h00, 32'h1, "stat_after_empty_rxd"});
    tbl.push_back('{8'h08, 32'h0, "txd_wo_reads_0"});
    tbl.push_back('{8'h0C, 32'h0, "flag_reset"});
    tbl.push_back('{8'h18, 32'h0, "clr_wo_reads_0"});
    tbl.push_back('{8'h1C, 32'h0, "unmapped_1c"});
    tbl.push_back('{8'h28, 32'h0, "evt2_absent"});
    tbl.push_back('{8'hFF, 32'h0, "unmapped_ff"});
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(1, 0, tbl[i].a, 4'h0, 32'h0);
      check(tbl[i].name, rd_data, tbl[i].exp);
    end

    // TX fill while the uart stalls; ninth byte dropped.
    tx_ready = 0;
    for (int k = 0; k < 9; k++) applyStimulus(0, 1, 8'h08, 4'h1, 32'hA5A5_A500 | (32'h41 + k));
    applyStimulus(1, 0, 8'h0C, 4'h0, 32'h0);
    check("tx_drop_set", rd_data, 32'h1);
    applyStimulus(1, 1, 8'h0C, 4'h1, 32'h1);
    check("flag_read_pre_clear", rd_data, 32'h1);
    applyStimulus(1, 0, 8'h0C, 4'h0, 32'h0);
    check("flag_after_clear", rd_data, 32'h0);
    tx_ready = 1;
    for (int k = 0; k < 8; k++) begin
      check("tx_order", tx_data, 32'h41 + k);
      applyStimulus(0, 0, 8'h00, 4'h0, 32'h0);
    end
    check("tx_drained", tx_valid, 32'h0);

    // RX fill to backpressure, then drain in order.
    rx_valid = 1;
    for (int k = 0; k < 8; k++) begin
      rx_data = 8'h61 + 8'(k);
      applyStimulus(0, 0, 8'h00, 4'h0, 32'h0);
    end
    rx_valid = 0;
    check("rx_full_backpressure", rx_ready, 32'h0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 0, 8'h04, 4'h0, 32'h0);
      check("rx_order", rd_data, 32'h61 + k);
    end
    applyStimulus(1, 0, 8'h00, 4'h0, 32'h0);
    check("stat_rx_drained", rd_data, 32'h1);

    // Full RX with push and pop together.
    rx_valid = 1;
    for (int k = 0; k < 8; k++) begin
      rx_data = 8'h10 + 8'(k);
      applyStimulus(0, 0, 8'h00, 4'h0, 32'h0);
    end
    rx_data = 8'h18;
    applyStimulus(1, 0, 8'h04, 4'h0, 32'h0);
    rx_valid = 0;
    check("rx_full_pushpop_head", rd_data, 32'h10);
    check("rx_full_pushpop_still_full", rx_ready, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1, 0, 8'h04, 4'h0, 32'h0);
      check("rx_pushpop_order", rd_data, 32'h10 + k);
    end

    // Instruction counter over 100 cycles, then clear.
    applyStimulus(0, 1, 8'h18, 4'hF, 32'h0);
    for (int c = 0; c < 100; c++) begin
      inst_ret = (c % 2 == 0);
      applyStimulus(0, 0, 8'h00, 4'h0, 32'h0);
    end
    inst_ret = 0;
    applyStimulus(1, 0, 8'h14, 4'h0, 32'h0);
    check("inst_count_50", rd_data, 32'd50);
    applyStimulus(0, 1, 8'h18, 4'h2, 32'h0);
    applyStimulus(0, 0, 8'h00, 4'h0, 32'h0);
    applyStimulus(1, 0, 8'h10, 4'h0, 32'h0);
    check("cyc_small_after_clr", (rd_data >= 1 && rd_data <= 3), 32'h1);

    // Event counter wrap on the 4-bit instance.
    applyStimulus(0, 1, 8'h18, 4'h1, 32'h0);
    evt = 2'b01;
    for (int c = 0; c < 17; c++) applyStimulus(0, 0, 8'h00, 4'h0, 32'h0);
    evt = 2'b00;
    applyStimulus(1, 0, 8'h20, 4'h0, 32'h0);
    check("evt0_wrap_cw4", rd_data4, 32'd1);
    check("evt0_cw32", rd_data, 32'd17);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(0, 3) == 0);
      inst_ret = 1'($urandom);
      evt      = 2'($urandom);
      applyStimulus(1'($urandom), ($urandom_range(0, 9) < 3),
                    ($urandom_range(0, 1) == 0) ? rdAddrs[$urandom_range(0, 9)] : wrAddrs[$urandom_range(0, 5)],
                    4'($urandom), $urandom);
    end

    // Reset in the middle of traffic empties both FIFOs at once.
    tx_ready = 0; rx_valid = 1; rx_data = 8'h77;
    applyStimulus(0, 1, 8'h08, 4'h1, 32'h55);
    applyStimulus(1, 1, 8'h08, 4'h1, 32'h56);
    rx_valid = 0; rd_en = 0; wr_en = 0;
    #2 rst_n = 0;
    #1;
    check("midreset_tx_valid", tx_valid, 32'h0);
    check("midreset_rx_ready", rx_ready, 32'h1);
    check("midreset_rd_data", rd_data, 32'h0);
    check("midreset_rd_valid", rd_valid, 32'h0);
    resetModel();
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    applyStimulus(1, 0, 8'h00, 4'h0, 32'h0);
    check("stat_after_midreset", rd_data, 32'h1);
    applyStimulus(1, 0, 8'h04, 4'h0, 32'h0);
    check("rxd_after_midreset", rd_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
